// File: rtl/arp_pkg.sv
// Shared constants, FSM state encoding and helpers for the ARP resolver.
package arp_pkg;

    localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;
    localparam logic [47:0] BCAST_MAC        = 48'hffff_ffff_ffff;
    localparam logic [31:0] BCAST_IP         = 32'hffff_ffff;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_QUERY      = 3'd1,
        ST_WAIT_CACHE = 3'd2,
        ST_SEND_REQ   = 3'd3,
        ST_WAIT_REPLY = 3'd4,
        ST_RESPOND    = 3'd5
    } arp_state_t;

    // Only well-formed requests/replies from a configured sender are worth caching.
    function automatic logic is_learnable(input logic [15:0] oper, input logic [31:0] spa);
        return ((oper == ARP_OPER_REQUEST) || (oper == ARP_OPER_REPLY)) && (spa != 32'h0);
    endfunction

endpackage

// File: rtl/arp_retry_timer.sv
// Down-counter pacing ARP request retries; saturates at zero, reloads on i_load.
module arp_retry_timer #(
    parameter int          TIMER_WIDTH    = 28,
    parameter int unsigned RETRY_INTERVAL = 250000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_tick,
    output logic o_expired
);

    localparam logic [TIMER_WIDTH-1:0] RELOAD = TIMER_WIDTH'(RETRY_INTERVAL - 1);

    logic [TIMER_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= RELOAD;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - TIMER_WIDTH'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/arp_resolver.sv
// Resolves next-hop MAC addresses through arp_cache, issuing timed ARP requests on a miss,
// and learns sender bindings from every received ARP packet.
module arp_resolver
    import arp_pkg::*;
#(
    parameter int          RETRY_COUNT    = 4,
    parameter int unsigned RETRY_INTERVAL = 250000000,
    parameter int          TIMER_WIDTH    = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_arp_req_valid,
    output logic        o_arp_req_ready,
    input  logic [31:0] i_arp_req_ip,
    output logic        o_arp_resp_valid,
    input  logic        i_arp_resp_ready,
    output logic        o_arp_resp_error,
    output logic [47:0] o_arp_resp_mac,
    output logic        o_cache_query_valid,
    input  logic        i_cache_query_ready,
    output logic [31:0] o_cache_query_ip,
    input  logic        i_cache_resp_valid,
    output logic        o_cache_resp_ready,
    input  logic        i_cache_resp_error,
    input  logic [47:0] i_cache_resp_mac,
    output logic        o_cache_write_valid,
    input  logic        i_cache_write_ready,
    output logic [31:0] o_cache_write_ip,
    output logic [47:0] o_cache_write_mac,
    input  logic        i_arp_rx_valid,
    output logic        o_arp_rx_ready,
    input  logic [15:0] i_arp_rx_oper,
    input  logic [47:0] i_arp_rx_sha,
    input  logic [31:0] i_arp_rx_spa,
    output logic        o_arp_tx_valid,
    input  logic        i_arp_tx_ready,
    output logic [15:0] o_arp_tx_oper,
    output logic [47:0] o_arp_tx_tha,
    output logic [31:0] o_arp_tx_tpa,
    input  logic [31:0] i_local_ip,
    input  logic [31:0] i_gateway_ip,
    input  logic [31:0] i_subnet_mask
);

    localparam int CNT_W = $clog2(RETRY_COUNT + 1);

    arp_state_t       r_state, w_state_next;
    logic             r_arp_req_ready, r_arp_resp_valid, r_arp_resp_error;
    logic [47:0]      r_arp_resp_mac;
    logic             r_cache_query_valid, r_cache_resp_ready;
    logic             r_cache_write_valid;
    logic [31:0]      r_cache_write_ip;
    logic [47:0]      r_cache_write_mac;
    logic             r_arp_rx_ready, r_arp_tx_valid;
    logic [15:0]      r_arp_tx_oper;
    logic [31:0]      r_next_hop;
    logic [CNT_W-1:0] r_retry_cnt;

    logic w_req_fire, w_query_fire, w_cresp_fire, w_tx_fire, w_resp_fire;
    logic w_rx_fire, w_wr_fire, w_learn, w_wr_valid_next;
    logic w_is_bcast, w_on_subnet, w_reply_match, w_retries_done;
    logic w_timer_tick, w_timer_expired;
    logic w_req_ready_next, w_query_valid_next, w_cresp_ready_next, w_tx_valid_next, w_resp_valid_next;

    assign w_req_fire    = i_arp_req_valid && r_arp_req_ready;
    assign w_query_fire  = r_cache_query_valid && i_cache_query_ready;
    assign w_cresp_fire  = i_cache_resp_valid && r_cache_resp_ready;
    assign w_tx_fire     = r_arp_tx_valid && i_arp_tx_ready;
    assign w_resp_fire   = r_arp_resp_valid && i_arp_resp_ready;
    assign w_rx_fire     = i_arp_rx_valid && r_arp_rx_ready;
    assign w_wr_fire     = r_cache_write_valid && i_cache_write_ready;
    assign w_learn       = w_rx_fire && is_learnable(i_arp_rx_oper, i_arp_rx_spa);

    assign w_is_bcast     = (i_arp_req_ip == BCAST_IP) || (i_arp_req_ip == (i_local_ip | ~i_subnet_mask));
    assign w_on_subnet    = ((i_arp_req_ip ^ i_local_ip) & i_subnet_mask) == 32'h0;
    assign w_reply_match  = w_rx_fire && (i_arp_rx_oper == ARP_OPER_REPLY) && (i_arp_rx_spa == r_next_hop);
    assign w_retries_done = (r_retry_cnt >= CNT_W'(RETRY_COUNT));
    assign w_timer_tick   = (r_state == ST_WAIT_REPLY);

    arp_retry_timer #(
        .TIMER_WIDTH   (TIMER_WIDTH),
        .RETRY_INTERVAL(RETRY_INTERVAL)
    ) u_retry_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_tx_fire),
        .i_tick   (w_timer_tick),
        .o_expired(w_timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_req_fire) w_state_next = w_is_bcast ? ST_RESPOND : ST_QUERY;
            ST_QUERY:      if (w_query_fire) w_state_next = ST_WAIT_CACHE;
            ST_WAIT_CACHE: if (w_cresp_fire) w_state_next = i_cache_resp_error ? ST_SEND_REQ : ST_RESPOND;
            ST_SEND_REQ:   if (w_tx_fire) w_state_next = ST_WAIT_REPLY;
            // A reply arriving on the expiry cycle takes priority over the retry decision.
            ST_WAIT_REPLY: begin
                if (w_reply_match)        w_state_next = ST_RESPOND;
                else if (w_timer_expired) w_state_next = w_retries_done ? ST_RESPOND : ST_SEND_REQ;
            end
            ST_RESPOND:    if (w_resp_fire) w_state_next = ST_IDLE;
            default:       w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decode the upcoming state so they can be registered without a lag cycle.
    always_comb begin
        w_req_ready_next   = (w_state_next == ST_IDLE);
        w_query_valid_next = (w_state_next == ST_QUERY);
        w_cresp_ready_next = (w_state_next == ST_WAIT_CACHE);
        w_tx_valid_next    = (w_state_next == ST_SEND_REQ);
        w_resp_valid_next  = (w_state_next == ST_RESPOND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arp_req_ready     <= 1'b0;
            r_cache_query_valid <= 1'b0;
            r_cache_resp_ready  <= 1'b0;
            r_arp_tx_valid      <= 1'b0;
            r_arp_resp_valid    <= 1'b0;
            r_arp_tx_oper       <= '0;
            r_next_hop          <= '0;
            r_arp_resp_mac      <= '0;
            r_arp_resp_error    <= 1'b0;
            r_retry_cnt         <= '0;
        end else begin
            r_arp_req_ready     <= w_req_ready_next;
            r_cache_query_valid <= w_query_valid_next;
            r_cache_resp_ready  <= w_cresp_ready_next;
            r_arp_tx_valid      <= w_tx_valid_next;
            r_arp_resp_valid    <= w_resp_valid_next;
            r_arp_tx_oper       <= w_tx_valid_next ? ARP_OPER_REQUEST : 16'h0;
            if (w_req_fire) begin
                r_next_hop <= w_on_subnet ? i_arp_req_ip : i_gateway_ip;
                if (w_is_bcast) begin
                    r_arp_resp_mac   <= BCAST_MAC;
                    r_arp_resp_error <= 1'b0;
                end
            end
            if ((r_state == ST_WAIT_CACHE) && w_cresp_fire) begin
                r_retry_cnt <= '0;
                if (!i_cache_resp_error) begin
                    r_arp_resp_mac   <= i_cache_resp_mac;
                    r_arp_resp_error <= 1'b0;
                end
            end
            if ((r_state == ST_SEND_REQ) && w_tx_fire) r_retry_cnt <= r_retry_cnt + CNT_W'(1);
            if (r_state == ST_WAIT_REPLY) begin
                if (w_reply_match) begin
                    r_arp_resp_mac   <= i_arp_rx_sha;
                    r_arp_resp_error <= 1'b0;
                end else if (w_timer_expired && w_retries_done) begin
                    r_arp_resp_mac   <= '0;
                    r_arp_resp_error <= 1'b1;
                end
            end
        end
    end

    // One-entry learning buffer; rx is only accepted while it is empty.
    assign w_wr_valid_next = w_learn || (r_cache_write_valid && !i_cache_write_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_write_valid <= 1'b0;
            r_cache_write_ip    <= '0;
            r_cache_write_mac   <= '0;
            r_arp_rx_ready      <= 1'b0;
        end else begin
            r_cache_write_valid <= w_wr_valid_next;
            r_arp_rx_ready      <= !w_wr_valid_next;
            if (w_learn) begin
                r_cache_write_ip  <= i_arp_rx_spa;
                r_cache_write_mac <= i_arp_rx_sha;
            end
        end
    end

    assign o_arp_req_ready     = r_arp_req_ready;
    assign o_arp_resp_valid    = r_arp_resp_valid;
    assign o_arp_resp_error    = r_arp_resp_error;
    assign o_arp_resp_mac      = r_arp_resp_mac;
    assign o_cache_query_valid = r_cache_query_valid;
    assign o_cache_query_ip    = r_next_hop;
    assign o_cache_resp_ready  = r_cache_resp_ready;
    assign o_cache_write_valid = r_cache_write_valid;
    assign o_cache_write_ip    = r_cache_write_ip;
    assign o_cache_write_mac   = r_cache_write_mac;
    assign o_arp_rx_ready      = r_arp_rx_ready;
    assign o_arp_tx_valid      = r_arp_tx_valid;
    assign o_arp_tx_oper       = r_arp_tx_oper;
    assign o_arp_tx_tha        = 48'h0;
    assign o_arp_tx_tpa        = r_next_hop;

endmodule
